// File: rtl/aabb_pixel_scanner_pkg.sv
// Shared coordinate and bounding-box types for the pixel scanner and its clamp.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package aabb_pixel_scanner_pkg;

    // Coordinate width of one point component; the scanner's COORD_W must match.
    localparam int AABB_COORD_W = 16;

    typedef struct packed {
        logic [AABB_COORD_W-1:0] x;
        logic [AABB_COORD_W-1:0] y;
    } point_t;

    typedef struct packed {
        point_t min_pt;
        point_t max_pt;
    } triangle_data_t;

    // A box is empty when its minimum corner lies past its maximum on either axis.
    function automatic logic box_is_empty(input triangle_data_t box);
        return (box.min_pt.x > box.max_pt.x) || (box.min_pt.y > box.max_pt.y);
    endfunction

endpackage

// File: rtl/aabb_clip.sv
// Clamps a bounding box to the visible screen area (combinational).
// Latency: 0 cycles, pure combinational.
// Backpressure: n/a, no handshake of its own.
module aabb_clip
    import aabb_pixel_scanner_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  triangle_data_t box_in,
    output triangle_data_t box_out
);

    localparam logic [AABB_COORD_W-1:0] X_LIM = AABB_COORD_W'(SCREEN_W - 1);
    localparam logic [AABB_COORD_W-1:0] Y_LIM = AABB_COORD_W'(SCREEN_H - 1);

    // Only the max corner needs clamping: coordinates are unsigned, so the lower
    // bound of zero always holds. A box lying wholly right of / below the screen
    // keeps its min beyond the clamped max and therefore reads as empty downstream.
    always_comb begin
        box_out = box_in;
        if (box_in.max_pt.x > X_LIM) begin
            box_out.max_pt.x = X_LIM;
        end
        if (box_in.max_pt.y > Y_LIM) begin
            box_out.max_pt.y = Y_LIM;
        end
    end

endmodule

// File: rtl/aabb_pixel_scanner.sv
// Walks every pixel of one bounding box in row-major order, one coordinate per beat.
// Latency: box accepted in cycle N -> first pixel valid in cycle N+1; one pixel/cycle.
// Backpressure: valid/ready; pixel and last held while stalled; new box only when idle.
// Optional screen clamp of the accepted box is enabled by defining AABB_SCAN_CLIP_EN.
module aabb_pixel_scanner
    import aabb_pixel_scanner_pkg::*;
#(
    parameter int COORD_W  = 16,
    parameter int CNT_W    = 32,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic             aClock,
    input  logic             aResetN,
    input  logic             aInValid,
    output logic             anOutInReady,
    input  triangle_data_t   aInAABB,
    output logic             anOutValid,
    input  logic             aOutReady,
    output point_t           anOutPixel,
    output logic             anOutLast,
    output logic [CNT_W-1:0] anOutPixelCount
);

    // Elaboration-time sanity checks on the configuration.
    if (COORD_W != AABB_COORD_W) begin : g_bad_coord_w
        $error("aabb_pixel_scanner: COORD_W must equal AABB_COORD_W");
    end
    if (SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_screen
        $error("aabb_pixel_scanner: SCREEN_W and SCREEN_H must be at least 1");
    end

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t           state_q, state_d;
    triangle_data_t   box_q, box_d;
    triangle_data_t   box_eff;
    point_t           pos_q, pos_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic beat;
    logic at_row_end;
    logic at_last;

`ifdef AABB_SCAN_CLIP_EN
    aabb_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clip (
        .box_in  (aInAABB),
        .box_out (box_eff)
    );
`else
    assign box_eff = aInAABB;
`endif

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign anOutInReady = aResetN && (state_q == ST_IDLE);
    assign accept       = aInValid && anOutInReady;

    // Compare against the max corner before incrementing so a box ending at the
    // top of the coordinate range terminates instead of wrapping.
    assign at_row_end   = (pos_q.x == box_q.max_pt.x);
    assign at_last      = at_row_end && (pos_q.y == box_q.max_pt.y);

    assign anOutValid      = (state_q == ST_SCAN);
    assign anOutLast       = anOutValid && at_last;
    assign anOutPixel      = pos_q;
    assign anOutPixelCount = cnt_q;
    assign beat            = anOutValid && aOutReady;

    // Next-state: capture the box on accept, advance the raster position per beat.
    always_comb begin
        state_d = state_q;
        box_d   = box_q;
        pos_d   = pos_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    box_d = box_eff;
                    pos_d = box_eff.min_pt;
                    cnt_d = '0;
                    // An empty box is consumed without emitting anything.
                    if (!box_is_empty(box_eff)) begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (beat) begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (at_last) begin
                        state_d = ST_IDLE;
                    end else if (!at_row_end) begin
                        pos_d.x = pos_q.x + 1'b1;
                    end else begin
                        pos_d.x = box_q.min_pt.x;
                        pos_d.y = pos_q.y + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset drops any box in flight.
    always_ff @(posedge aClock) begin
        if (!aResetN) begin
            state_q <= ST_IDLE;
            box_q   <= '0;
            pos_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            box_q   <= box_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_aabb_pixel_scanner.sv
module tb_aabb_pixel_scanner;
    import aabb_pixel_scanner_pkg::*;

    logic           aClock;
    logic           aResetN;
    logic           aInValid;
    logic           anOutInReady;
    triangle_data_t aInAABB;
    logic           anOutValid;
    logic           aOutReady;
    point_t         anOutPixel;
    logic           anOutLast;
    logic [31:0]    anOutPixelCount;

    int total;
    int bad;

    int got_x[$];
    int got_y[$];
    bit got_last[$];
    int stall_viol;
    int stall_seen;
    bit timed_out;
    int first_valid_cyc;

    aabb_pixel_scanner #(
        .COORD_W  (16),
        .CNT_W    (32),
        .SCREEN_W (640),
        .SCREEN_H (480)
    ) dut (
        .aClock          (aClock),
        .aResetN         (aResetN),
        .aInValid        (aInValid),
        .anOutInReady    (anOutInReady),
        .aInAABB         (aInAABB),
        .anOutValid      (anOutValid),
        .aOutReady       (aOutReady),
        .anOutPixel      (anOutPixel),
        .anOutLast       (anOutLast),
        .anOutPixelCount (anOutPixelCount)
    );

    initial aClock = 1'b0;
    always #5 aClock = ~aClock;

    // Presents a box, waits (bounded) for acceptance, then scrambles the input bus.
    task automatic send_box(input int mnx, input int mny, input int mxx, input int mxy);
        bit ok;
        ok = 1'b0;
        aInAABB.min_pt.x = 16'(mnx);
        aInAABB.min_pt.y = 16'(mny);
        aInAABB.max_pt.x = 16'(mxx);
        aInAABB.max_pt.y = 16'(mxy);
        aInValid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge aClock);
            if (anOutInReady === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout: ready never seen, got 0 want 1");
        end
        @(posedge aClock);
        #1;
        aInValid = 1'b0;
        aInAABB  = triangle_data_t'($urandom());
    endtask

    // Records beats until the last beat, stop_beats beats, or the cycle budget.
    task automatic collect(input int max_cyc, input bit rand_rdy, input int stop_beats);
        bit     prev_stall;
        point_t prev_pix;
        bit     prev_last;
        bit     done;
        int     nb;
        got_x.delete();
        got_y.delete();
        got_last.delete();
        stall_viol      = 0;
        stall_seen      = 0;
        timed_out       = 1'b1;
        first_valid_cyc = -1;
        prev_stall      = 1'b0;
        prev_pix        = '0;
        prev_last       = 1'b0;
        nb              = 0;
        aOutReady = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge aClock);
            if (prev_stall && (anOutValid !== 1'b1 || anOutPixel !== prev_pix ||
                               anOutLast !== prev_last)) begin
                stall_viol++;
            end
            if (anOutValid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = c;
            prev_stall = (anOutValid === 1'b1) && !aOutReady;
            if (prev_stall) stall_seen++;
            prev_pix  = anOutPixel;
            prev_last = anOutLast;
            done = 1'b0;
            if (anOutValid === 1'b1 && aOutReady) begin
                got_x.push_back(int'(anOutPixel.x));
                got_y.push_back(int'(anOutPixel.y));
                got_last.push_back(anOutLast);
                nb++;
                done = (anOutLast === 1'b1) || (nb == stop_beats);
            end
            @(posedge aClock);
            #1;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            aOutReady = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        aOutReady = 1'b1;
    endtask

    task automatic test_reset();
        aResetN   = 1'b0;
        aInValid  = 1'b0;
        aOutReady = 1'b1;
        aInAABB   = '0;
        repeat (2) @(posedge aClock);
        @(negedge aClock);
        total++;
        if (anOutValid !== 1'b0 || anOutLast !== 1'b0 || anOutPixel !== '0 ||
            anOutPixelCount !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%0b l=%0b px=%h cnt=%0d want 0 0 0 0",
                     anOutValid, anOutLast, anOutPixel, anOutPixelCount);
        end
        total++;
        if (anOutInReady !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_low: got %0b want 0", anOutInReady);
        end
        @(posedge aClock);
        #1;
        aResetN = 1'b1;
        @(posedge aClock);
        @(negedge aClock);
        total++;
        if (anOutInReady !== 1'b1 || anOutValid !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got rdy=%0b v=%0b want 1 0", anOutInReady, anOutValid);
        end
        @(posedge aClock);
        #1;
    endtask

    task automatic test_basic();
        int ex[6] = '{2, 3, 4, 2, 3, 4};
        int ey[6] = '{3, 3, 3, 4, 4, 4};
        send_box(2, 3, 4, 4);
        collect(100, 1'b0, 0);
        total++;
        if (timed_out || got_x.size() != 6) begin
            bad++;
            $display("FAIL basic_beats: got %0d want 6 (timeout=%0b)", got_x.size(), timed_out);
        end
        total++;
        if (first_valid_cyc != 0) begin
            bad++;
            $display("FAIL basic_latency: got cycle %0d want 0", first_valid_cyc);
        end
        for (int i = 0; i < 6 && i < got_x.size(); i++) begin
            total++;
            if (got_x[i] != ex[i] || got_y[i] != ey[i] || got_last[i] != (i == 5)) begin
                bad++;
                $display("FAIL basic_pixel%0d: got (%0d,%0d) last=%0b want (%0d,%0d) last=%0b",
                         i, got_x[i], got_y[i], got_last[i], ex[i], ey[i], i == 5);
            end
        end
        @(negedge aClock);
        total++;
        if (anOutInReady !== 1'b1 || anOutValid !== 1'b0 || anOutPixelCount !== 32'd6) begin
            bad++;
            $display("FAIL basic_done: got rdy=%0b v=%0b cnt=%0d want 1 0 6",
                     anOutInReady, anOutValid, anOutPixelCount);
        end
        @(posedge aClock);
        #1;
    endtask

    task automatic test_backpressure();
        int ex[6] = '{2, 3, 4, 2, 3, 4};
        int ey[6] = '{3, 3, 3, 4, 4, 4};
        send_box(2, 3, 4, 4);
        collect(400, 1'b1, 0);
        total++;
        if (timed_out || got_x.size() != 6) begin
            bad++;
            $display("FAIL bp_beats: got %0d want 6 (timeout=%0b)", got_x.size(), timed_out);
        end
        total++;
        if (stall_viol != 0) begin
            bad++;
            $display("FAIL bp_stable: got %0d unstable stalls want 0 (stalls=%0d)",
                     stall_viol, stall_seen);
        end
        for (int i = 0; i < 6 && i < got_x.size(); i++) begin
            total++;
            if (got_x[i] != ex[i] || got_y[i] != ey[i] || got_last[i] != (i == 5)) begin
                bad++;
                $display("FAIL bp_pixel%0d: got (%0d,%0d) last=%0b want (%0d,%0d) last=%0b",
                         i, got_x[i], got_y[i], got_last[i], ex[i], ey[i], i == 5);
            end
        end
        @(negedge aClock);
        total++;
        if (anOutPixelCount !== 32'd6) begin
            bad++;
            $display("FAIL bp_count: got %0d want 6", anOutPixelCount);
        end
        @(posedge aClock);
        #1;
    endtask

    task automatic test_single();
        send_box(5, 5, 5, 5);
        collect(20, 1'b0, 0);
        total++;
        if (got_x.size() != 1 || got_x[0] != 5 || got_y[0] != 5 || got_last[0] != 1'b1) begin
            bad++;
            $display("FAIL single_beat: got n=%0d want one beat (5,5) last=1", got_x.size());
        end
        @(negedge aClock);
        total++;
        if (anOutPixelCount !== 32'd1 || anOutInReady !== 1'b1) begin
            bad++;
            $display("FAIL single_done: got cnt=%0d rdy=%0b want 1 1",
                     anOutPixelCount, anOutInReady);
        end
        @(posedge aClock);
        #1;
    endtask

    task automatic test_empty();
        int vseen;
        vseen = 0;
        send_box(9, 0, 3, 0);
        @(negedge aClock);
        total++;
        if (anOutInReady !== 1'b1 || anOutValid !== 1'b0 || anOutPixelCount !== 32'd0) begin
            bad++;
            $display("FAIL empty_next: got rdy=%0b v=%0b cnt=%0d want 1 0 0",
                     anOutInReady, anOutValid, anOutPixelCount);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge aClock);
            if (anOutValid !== 1'b0) vseen++;
        end
        total++;
        if (vseen != 0) begin
            bad++;
            $display("FAIL empty_no_valid: got %0d valid cycles want 0", vseen);
        end
        @(posedge aClock);
        #1;
    endtask

    task automatic test_wrap();
        int ex[6] = '{65533, 65534, 65535, 65533, 65534, 65535};
        int ey[6] = '{0, 0, 0, 1, 1, 1};
        send_box(65533, 0, 65535, 1);
        collect(100, 1'b0, 0);
        total++;
        if (timed_out || got_x.size() != 6) begin
            bad++;
            $display("FAIL wrap_beats: got %0d want 6 (timeout=%0b)", got_x.size(), timed_out);
        end
        for (int i = 0; i < 6 && i < got_x.size(); i++) begin
            total++;
            if (got_x[i] != ex[i] || got_y[i] != ey[i] || got_last[i] != (i == 5)) begin
                bad++;
                $display("FAIL wrap_pixel%0d: got (%0d,%0d) last=%0b want (%0d,%0d) last=%0b",
                         i, got_x[i], got_y[i], got_last[i], ex[i], ey[i], i == 5);
            end
        end
        @(posedge aClock);
        #1;
    endtask

    task automatic test_mid_reset();
        int vseen;
        vseen = 0;
        send_box(0, 0, 7, 7);
        collect(50, 1'b0, 3);
        total++;
        if (got_x.size() != 3 || got_x[2] != 2 || got_y[2] != 0) begin
            bad++;
            $display("FAIL midrst_pre: got n=%0d want 3 beats ending (2,0)", got_x.size());
        end
        aResetN = 1'b0;
        @(posedge aClock);
        @(negedge aClock);
        total++;
        if (anOutValid !== 1'b0 || anOutPixelCount !== 32'd0 || anOutLast !== 1'b0) begin
            bad++;
            $display("FAIL midrst_cleared: got v=%0b cnt=%0d l=%0b want 0 0 0",
                     anOutValid, anOutPixelCount, anOutLast);
        end
        @(posedge aClock);
        #1;
        aResetN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aClock);
            if (anOutValid !== 1'b0) vseen++;
        end
        total++;
        if (vseen != 0 || anOutInReady !== 1'b1) begin
            bad++;
            $display("FAIL midrst_idle: got valid_cycles=%0d rdy=%0b want 0 1", vseen, anOutInReady);
        end
        @(posedge aClock);
        #1;
    endtask

`ifdef AABB_SCAN_CLIP_EN
    task automatic test_clip();
        send_box(638, 0, 700, 0);
        collect(50, 1'b0, 0);
        total++;
        if (got_x.size() != 2 || got_x[0] != 638 || got_x[1] != 639 ||
            got_y[1] != 0 || got_last[1] != 1'b1) begin
            bad++;
            $display("FAIL clip_beats: got n=%0d want 2 beats (638,0)(639,0)", got_x.size());
        end
        @(posedge aClock);
        #1;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_single();
        test_empty();
        test_wrap();
        test_mid_reset();
`ifdef AABB_SCAN_CLIP_EN
        test_clip();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
